// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: scan result encoding,
// key map and column strobe patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    KS_NONE  = 2'd0,
    KS_KEY   = 2'd1,
    KS_MULTI = 2'd2
  } kstate_e;

  // code is kept at zero for NONE and MULTI so whole-struct compares are exact
  typedef struct packed {
    kstate_e    kind;
    logic [3:0] code;
  } kres_t;

  localparam kres_t RES_NONE = '{kind: KS_NONE, code: 4'h0};

  // indexed by row*4 + column
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [3:0] COL_STROBE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic kres_t classify(logic [15:0] image);
    int         n;
    logic [3:0] idx;
    kres_t      r;
    n   = 0;
    idx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (image[i]) begin
        n   = n + 1;
        idx = 4'(i);
      end
    end
    r = RES_NONE;
    if (n == 1)
      r = '{kind: KS_KEY, code: KEY_MAP[idx]};
    else if (n > 1)
      r = '{kind: KS_MULTI, code: 4'h0};
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row sense in, column strobe and key event outputs.
interface keypad_scanner_if;
  logic [3:0] row_k;
  logic [3:0] col_k;
  logic [3:0] key_code_k;
  logic       key_valid_k;
  logic       key_held_k;

  modport master (
    input  row_k,
    output col_k, key_code_k, key_valid_k, key_held_k
  );

  modport slave (
    output row_k,
    input  col_k, key_code_k, key_valid_k, key_held_k
  );
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Scan-to-scan debounce and commit logic for the keypad scanner.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
//
// debounced state | meaning
// KS_NONE         | no key down
// KS_KEY          | exactly one key down, code in deb_q.code
// KS_MULTI        | two or more keys down, reported as no key
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk_k,
  input  logic       rst_k,
  input  logic       scan_done,
  input  kres_t      raw,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] CNT_FULL = 4'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_cfg
    $error("keypad_debounce: parameter out of range");
  end

  kres_t      cand_q, cand_d;
  kres_t      deb_q, deb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       pulse_q, pulse_d;
  logic       commit;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk_k) begin
    if (rst_k) begin
      cand_q  <= RES_NONE;
      deb_q   <= RES_NONE;
      cnt_q   <= 4'd0;
      code_q  <= 4'h0;
      pulse_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (scan_done) begin
      if (raw == cand_q) begin
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = raw;
        cnt_d  = 4'd1;
      end
    end
  end

  assign commit = scan_done && (cnt_d == CNT_FULL) && (cand_d != deb_q);

  always_comb begin
    deb_d   = deb_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    if (commit) begin
      deb_d = cand_d;
      if (cand_d.kind == KS_KEY) begin
        code_d  = cand_d.code;
        pulse_d = 1'b1;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    // a commit on the same edge as a repeat tick wins and restarts the interval
    rep_d = rep_q;
    if (commit) begin
      rep_d = '0;
    end else if (scan_done && deb_q.kind == KS_KEY) begin
      if (rep_q + 1'b1 == REP_LAST) begin
        rep_d   = '0;
        pulse_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    key_code  = code_q;
    key_valid = pulse_q;
    key_held  = (deb_q.kind == KS_KEY);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchroniser, scan capture and
// classification; debounce lives in keypad_debounce. Auto-repeat: KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic             clk_k,
  input  logic             rst_k,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("keypad_scanner: SCAN_DIV must be at least 4");
  end

  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [15:0]   image;
  logic          scan_done;
  logic          dwell_last;
  kres_t         raw;

  assign dwell_last = (dwell == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk_k) begin
    if (rst_k) begin
      dwell     <= '0;
      col_idx   <= 2'd0;
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      image     <= 16'h0000;
      scan_done <= 1'b0;
    end else begin
      row_s1    <= kp.row_k;
      row_s2    <= row_s1;
      scan_done <= dwell_last && (col_idx == 2'd3);
      if (dwell_last) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        // rows are active-low; a set image bit means the key is down
        for (int r = 0; r < 4; r++)
          image[{2'(r), col_idx}] <= ~row_s2[r];
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign kp.col_k = COL_STROBE[col_idx];

  always_comb begin
    raw = classify(image);
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk_k     (clk_k),
    .rst_k     (rst_k),
    .scan_done (scan_done),
    .raw       (raw),
    .key_code  (kp.key_code_k),
    .key_valid (kp.key_valid_k),
    .key_held  (kp.key_held_k)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, pulse scoreboard,
// table-driven press/release steps plus latency, reset and repeat sequences.
module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if bus();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (4)
  ) dut (
    .clk_k (clk),
    .rst_k (rst),
    .kp    (bus)
  );

  logic [15:0] keys = 16'h0000;

  // key (r,c) pulls row r low while column c is strobed
  always_comb begin
    bus.row_k = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !bus.col_k[c]) bus.row_k[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  logic [3:0] exp_q [$];
  int         pulse_t [$];
  logic [3:0] e;
  logic watch_held   = 1'b0;
  logic held_dropped = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (watch_held && !bus.key_held_k) held_dropped = 1'b1;
      if (!rst && bus.key_valid_k) begin
        pulses = pulses + 1;
        pulse_t.push_back(cyc);
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_pulse: got pulse code=%h at cycle %0d, required no pulse", bus.key_code_k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.key_code_k !== e) begin
            bad = bad + 1;
            $display("FAIL pulse_code: got %h, required %h", bus.key_code_k, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // leaves the bench at the negedge of the first cycle of column 0
  task automatic align();
    int n;
    n = 0;
    while (bus.col_k != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (bus.col_k != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    check("align_in_time", 32'(n < 64), 32'd1);
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] k;
    int          scans;
    bit          pulse;
    logic [3:0]  code;
    bit          held;
    bit          watch;
  } vec_t;

  vec_t vt [15];
  logic [3:0] col_pat [4];
  int lat;
  int p0;
  int n;

  initial begin
    vt[0]  = '{16'h0400, 4,  1'b1, 4'h9, 1'b1, 1'b0};
    vt[1]  = '{16'h4000, 4,  1'b1, 4'hE, 1'b1, 1'b1};
    vt[2]  = '{16'h0000, 4,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[3]  = '{16'h0002, 2,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[4]  = '{16'h0000, 1,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[5]  = '{16'h0002, 2,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[6]  = '{16'h0000, 1,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[7]  = '{16'h0002, 2,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[8]  = '{16'h0000, 1,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[9]  = '{16'h0005, 10, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[10] = '{16'h0001, 4,  1'b1, 4'h1, 1'b1, 1'b0};
    vt[11] = '{16'h0000, 4,  1'b0, 4'h0, 1'b0, 1'b0};
    vt[12] = '{16'h1000, 4,  1'b1, 4'h0, 1'b1, 1'b0};
    vt[13] = '{16'h8000, 4,  1'b1, 4'hD, 1'b1, 1'b0};
    vt[14] = '{16'h0000, 4,  1'b0, 4'h0, 1'b0, 1'b0};
    col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_col",   32'(bus.col_k),       32'hE);
    check("reset_code",  32'(bus.key_code_k),  32'h0);
    check("reset_valid", 32'(bus.key_valid_k), 32'h0);
    check("reset_held",  32'(bus.key_held_k),  32'h0);
    rst = 1'b0;

    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check("idle_col", 32'(bus.col_k), 32'(col_pat[(i/4)%4]));
    end
    check("idle_held", 32'(bus.key_held_k), 32'h0);

    // press latency of key 5 from the start of a scan
    align();
    keys = 16'h0020;
    exp_q.push_back(4'h5);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.key_valid_k && lat < 200);
    total = total + 1;
    if (lat < 48 || lat > 67) begin
      bad = bad + 1;
      $display("FAIL press_latency: got %0d cycles, required 48..67", lat);
    end
    check("held_after_press", 32'(bus.key_held_k), 32'h1);
    repeat (64 - lat) @(negedge clk);
    check("held_before_release", 32'(bus.key_held_k), 32'h1);
    keys = 16'h0000;
    run_scans(4);
    check("held_after_release", 32'(bus.key_held_k), 32'h0);
    check("pending_latency", 32'(exp_q.size()), 32'h0);

    for (int i = 0; i < 15; i++) begin
      keys = vt[i].k;
      watch_held = vt[i].watch;
      if (vt[i].pulse) exp_q.push_back(vt[i].code);
      run_scans(vt[i].scans);
      check($sformatf("step%0d_held", i), 32'(bus.key_held_k), 32'(vt[i].held));
      check($sformatf("step%0d_pending", i), 32'(exp_q.size()), 32'h0);
    end
    watch_held = 1'b0;
    check("held_through_key_change", 32'(held_dropped), 32'h0);

`ifdef KEYPAD_REPEAT_EN
    keys = 16'h0008;
    repeat (6) exp_q.push_back(4'hA);
    p0 = pulses;
    n = 0;
    while (pulses - p0 < 6 && n < 500) begin @(negedge clk); n++; end
    check("repeat_count", 32'(pulses - p0), 32'd6);
    for (int k = 1; k < pulses - p0; k++)
      check("repeat_gap", 32'(pulse_t[p0+k] - pulse_t[p0+k-1]), 32'd64);
    keys = 16'h0000;
    run_scans(5);
    check("repeat_release_held", 32'(bus.key_held_k), 32'h0);
    check("repeat_pending", 32'(exp_q.size()), 32'h0);
`endif

    // reset while a key is held, then re-report after reset
    align();
    keys = 16'h0008;
    exp_q.push_back(4'hA);
    n = 0;
    while (!bus.key_held_k && n < 100) begin @(negedge clk); n++; end
    check("rst_hold_held", 32'(bus.key_held_k), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_clears_held",  32'(bus.key_held_k),  32'h0);
    check("rst_clears_valid", 32'(bus.key_valid_k), 32'h0);
    check("rst_col",          32'(bus.col_k),       32'hE);
    rst = 1'b0;
    exp_q.push_back(4'hA);
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin @(negedge clk); n++; end
    check("rereport_pending", 32'(exp_q.size()), 32'h0);
    check("rereport_held", 32'(bus.key_held_k), 32'h1);
    keys = 16'h0000;
    run_scans(5);
    check("final_held", 32'(bus.key_held_k), 32'h0);
    check("leftover", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
